// File: rtl/debouncer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debouncer_pkg
//  Description : Shared types, constants and helper functions for the
//                multi-channel debouncer (debouncer_mc / debounce_channel).
//  Revision    : 1.0 - initial release
// ============================================================================
package debouncer_pkg;

   // Per-channel qualify FSM states, 2-bit encoding
   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_QUAL   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_QUAL = 2'd3
   } state_e;

   // Prescaler produces one tick per millisecond
   localparam int unsigned TICK_RATE_HZ = 1000;

   // Bits needed to hold values 0..value-1; never returns less than 1
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      longint unsigned span;
      result = 0;
      span   = 1;
      while (span < longint'(value)) begin
         span   = span << 1;
         result = result + 1;
      end
      return (result == 0) ? 1 : result;
   endfunction

   // Terminal count of the millisecond prescaler
   function automatic int unsigned presc_terminal(input int unsigned clk_hz);
      return (clk_hz / TICK_RATE_HZ) - 1;
   endfunction

   // Legality of the top-level parameters
   function automatic bit top_params_ok(input int unsigned ch_num,
                                        input int unsigned clk_hz);
      return (ch_num >= 1) && (ch_num <= 32) && (clk_hz >= TICK_RATE_HZ);
   endfunction

   // Legality of the per-channel timing parameters
   function automatic bit channel_params_ok(input int unsigned debounce_ms,
                                            input int unsigned long_press_ms,
                                            input int unsigned repeat_ms,
                                            input int unsigned sync_stages);
      return (debounce_ms >= 1) && (long_press_ms > debounce_ms) &&
             (repeat_ms >= 1) && (sync_stages >= 2) && (sync_stages <= 10);
   endfunction

endpackage : debouncer_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One debouncer channel: input synchronizer, press/release
//                qualify FSM, hold counter with long-press detection and
//                optional auto-repeat (enabled by DEBOUNCER_AUTOREPEAT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
   import debouncer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_MS   = 20,
   parameter int unsigned LONG_PRESS_MS = 1000,
   parameter int unsigned REPEAT_MS     = 200,
   parameter logic        IDLE_STATE    = 1'b1,
   parameter int unsigned SYNC_STAGES   = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic noisy_in,
   output logic filtered_out,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   localparam int unsigned QW = clog2(DEBOUNCE_MS + 1);
   localparam int unsigned HW = clog2(LONG_PRESS_MS + 1);
   localparam logic [QW-1:0] QCNT_LAST = QW'(DEBOUNCE_MS - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_MS - 1);

   if (!channel_params_ok(DEBOUNCE_MS, LONG_PRESS_MS, REPEAT_MS, SYNC_STAGES)) begin : g_param_check
      $error("debounce_channel: illegal timing or synchronizer parameters");
   end

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_e                 state_q, state_d;
   logic [QW-1:0]          qcnt_q, qcnt_d;
   logic [HW-1:0]          hold_q, hold_d;
   logic                   long_q, long_d;
   logic                   filtered_q, filtered_d;
   logic                   press_q, press_d;
   logic                   release_q, release_d;
   logic                   long_pulse_q, long_pulse_d;
   logic                   s_active;

   // Synchronizer shift and activity decode of the last stage
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], noisy_in};
      s_active = (sync_q[SYNC_STAGES-1] != IDLE_STATE);
   end

   // Qualify FSM: next state, counters and registered pulse outputs
   always_comb begin
      state_d      = state_q;
      qcnt_d       = qcnt_q;
      hold_d       = hold_q;
      long_d       = long_q;
      filtered_d   = filtered_q;
      press_d      = 1'b0;
      release_d    = 1'b0;
      long_pulse_d = 1'b0;
      case (state_q)
         ST_RELEASED: begin
            if (s_active) begin
               state_d = ST_PRESS_QUAL;
               qcnt_d  = '0;
            end
         end
         ST_PRESS_QUAL: begin
            // A return to idle always wins over a coincident tick
            if (!s_active) begin
               state_d = ST_RELEASED;
            end else if (tick) begin
               if (qcnt_q == QCNT_LAST) begin
                  state_d    = ST_PRESSED;
                  filtered_d = ~IDLE_STATE;
                  press_d    = 1'b1;
                  hold_d     = '0;
                  long_d     = 1'b0;
               end else begin
                  qcnt_d = qcnt_q + 1'b1;
               end
            end
         end
         ST_PRESSED: begin
            if (tick) begin
               if (hold_q != '1) begin
                  hold_d = hold_q + 1'b1;
               end
               if ((hold_q == HOLD_LAST) && !long_q) begin
                  long_pulse_d = 1'b1;
                  long_d       = 1'b1;
               end
            end
            if (!s_active) begin
               state_d = ST_RELEASE_QUAL;
               qcnt_d  = '0;
            end
         end
         ST_RELEASE_QUAL: begin
            // Hold counter is frozen here; a bounce back keeps hold and long
            if (s_active) begin
               state_d = ST_PRESSED;
            end else if (tick) begin
               if (qcnt_q == QCNT_LAST) begin
                  state_d    = ST_RELEASED;
                  filtered_d = IDLE_STATE;
                  release_d  = 1'b1;
               end else begin
                  qcnt_d = qcnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_RELEASED;
         end
      endcase
   end

   // State, counter, synchronizer and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q       <= {SYNC_STAGES{IDLE_STATE}};
         state_q      <= ST_RELEASED;
         qcnt_q       <= '0;
         hold_q       <= '0;
         long_q       <= 1'b0;
         filtered_q   <= IDLE_STATE;
         press_q      <= 1'b0;
         release_q    <= 1'b0;
         long_pulse_q <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         state_q      <= state_d;
         qcnt_q       <= qcnt_d;
         hold_q       <= hold_d;
         long_q       <= long_d;
         filtered_q   <= filtered_d;
         press_q      <= press_d;
         release_q    <= release_d;
         long_pulse_q <= long_pulse_d;
      end
   end

   assign filtered_out  = filtered_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign long_pulse    = long_pulse_q;

`ifdef DEBOUNCER_AUTOREPEAT_EN
   localparam int unsigned RW = clog2(REPEAT_MS + 1);
   localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_MS - 1);

   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          repeat_q, repeat_d;

   // Auto-repeat: counts ticks while held past the long-press point
   always_comb begin
      rcnt_d   = rcnt_q;
      repeat_d = 1'b0;
      if (state_q == ST_PRESSED) begin
         if (tick && long_q) begin
            if (rcnt_q == RCNT_LAST) begin
               repeat_d = 1'b1;
               rcnt_d   = '0;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         if (!s_active) begin
            rcnt_d = '0;
         end
      end else begin
         rcnt_d = '0;
      end
   end

   // Auto-repeat registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rcnt_q   <= '0;
         repeat_q <= 1'b0;
      end else begin
         rcnt_q   <= rcnt_d;
         repeat_q <= repeat_d;
      end
   end

   assign repeat_pulse = repeat_q;
`else
   assign repeat_pulse = 1'b0;
`endif

endmodule : debounce_channel
`default_nettype wire

// File: rtl/debouncer_mc.sv
`default_nettype none
// ============================================================================
//  Module      : debouncer_mc
//  Description : Multi-channel switch debouncer. Holds the shared 1 ms tick
//                prescaler and CH_NUM independent debounce_channel instances.
//                Optional auto-repeat: define DEBOUNCER_AUTOREPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module debouncer_mc
   import debouncer_pkg::*;
#(
   parameter int unsigned CH_NUM        = 4,
   parameter int unsigned CLK_HZ        = 27000000,
   parameter int unsigned DEBOUNCE_MS   = 20,
   parameter int unsigned LONG_PRESS_MS = 1000,
   parameter int unsigned REPEAT_MS     = 200,
   parameter logic        IDLE_STATE    = 1'b1,
   parameter int unsigned SYNC_STAGES   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CH_NUM-1:0] noisy_in,
   output logic [CH_NUM-1:0] filtered_out,
   output logic [CH_NUM-1:0] press_pulse,
   output logic [CH_NUM-1:0] release_pulse,
   output logic [CH_NUM-1:0] long_pulse,
   output logic [CH_NUM-1:0] repeat_pulse
);

   localparam int unsigned   PRESC_LAST   = presc_terminal(CLK_HZ);
   localparam int unsigned   PW           = clog2(PRESC_LAST + 1);
   localparam logic [PW-1:0] PRESC_LAST_V = PW'(PRESC_LAST);

   if (!top_params_ok(CH_NUM, CLK_HZ)) begin : g_param_check
      $error("debouncer_mc: illegal CH_NUM or CLK_HZ");
   end

   logic [PW-1:0] presc_q, presc_d;
   logic          tick;

   // Millisecond prescaler: tick is high during the terminal count cycle
   always_comb begin
      tick    = (presc_q == PRESC_LAST_V);
      presc_d = tick ? '0 : presc_q + 1'b1;
   end

   // Prescaler register
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_MS   (DEBOUNCE_MS),
         .LONG_PRESS_MS (LONG_PRESS_MS),
         .REPEAT_MS     (REPEAT_MS),
         .IDLE_STATE    (IDLE_STATE),
         .SYNC_STAGES   (SYNC_STAGES)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .tick          (tick),
         .noisy_in      (noisy_in[g]),
         .filtered_out  (filtered_out[g]),
         .press_pulse   (press_pulse[g]),
         .release_pulse (release_pulse[g]),
         .long_pulse    (long_pulse[g]),
         .repeat_pulse  (repeat_pulse[g])
      );
   end

endmodule : debouncer_mc
`default_nettype wire
